fifo_word_packer: RTL and testbench

Downstream stage of the generic valid/grant FIFO. Pops `RATIO` consecutive narrow words from the FIFO pop side and presents them as one wide word on a valid/grant output towards the consuming interconnect port. An optional flush forces out a partially filled word with a slot strobe. Both ports use the same valid/grant handshake as the FIFO.

---
 rtl/fifo_packer_pkg.sv | 20 ++
 rtl/fifo_word_packer.sv | 112 +++++++++++
 tb/tb_fifo_word_packer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/fifo_packer_pkg.sv
// ============================================================================
// fifo_packer_pkg : shared types and helpers for the FIFO word packer
// Rev 1.0
// ============================================================================
`default_nettype none

package fifo_packer_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } packer_state_t;

  function automatic int packer_cnt_width(input int ratio);
    return $clog2(ratio);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_word_packer.sv
// ============================================================================
// fifo_word_packer : packs RATIO narrow FIFO words into one wide valid/grant
// word. Optional partial-word flush enabled by macro PACKER_FLUSH_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module fifo_word_packer
  import fifo_packer_pkg::*;
#(
  parameter int IN_WIDTH = 32,
  parameter int RATIO    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [IN_WIDTH-1:0]       data_i,
  input  logic                      valid_i,
  output logic                      grant_o,
  input  logic                      flush_i,
  output logic [IN_WIDTH*RATIO-1:0] data_o,
  output logic [RATIO-1:0]          strb_o,
  output logic                      valid_o,
  input  logic                      grant_i
);

  localparam int               CNT_W     = packer_cnt_width(RATIO);
  localparam int               OUT_W     = IN_WIDTH * RATIO;
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(RATIO - 1);

  packer_state_t    state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [OUT_W-1:0] word_q, word_n;
  logic [RATIO-1:0] strb_q, strb_n;
  logic             flush_req;

`ifdef PACKER_FLUSH_EN
  assign flush_req = flush_i;
`else
  logic unused_flush;
  assign unused_flush = flush_i;
  assign flush_req    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= COLLECT;
      cnt    <= '0;
      word_q <= '0;
      strb_q <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      word_q <= word_n;
      strb_q <= strb_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    word_n  = word_q;
    strb_n  = strb_q;
    grant_o = 1'b0;
    case (state)
      COLLECT: begin
        grant_o = 1'b1;
        if (valid_i) begin
          for (int k = 0; k < RATIO; k++) begin
            if (cnt == CNT_W'(k)) begin
              word_n[k*IN_WIDTH +: IN_WIDTH] = data_i;
              strb_n[k]                      = 1'b1;
            end
          end
        end
        // A flush with nothing collected and nothing arriving has no word to emit.
        if ((valid_i && (cnt == LAST_SLOT)) ||
            (flush_req && (valid_i || (cnt != '0)))) begin
          state_n = HOLD;
          cnt_n   = '0;
        end else if (valid_i) begin
          cnt_n = cnt + 1'b1;
        end
      end
      HOLD: begin
        // Grant follows the consumer so the next group's first word is not stalled.
        grant_o = grant_i;
        if (grant_i) begin
          state_n = COLLECT;
          word_n  = '0;
          strb_n  = '0;
          cnt_n   = '0;
          if (valid_i) begin
            word_n[IN_WIDTH-1:0] = data_i;
            strb_n[0]            = 1'b1;
            cnt_n                = CNT_W'(1);
          end
        end
      end
      default: begin
        state_n = COLLECT;
        cnt_n   = '0;
      end
    endcase
  end

  assign data_o  = word_q;
  assign strb_o  = strb_q;
  assign valid_o = (state == HOLD);

endmodule

`default_nettype wire

// File: tb/tb_fifo_word_packer.sv
// ============================================================================
// tb_fifo_word_packer : directed self-checking bench for fifo_word_packer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fifo_word_packer;

  localparam int IN_WIDTH = 32;
  localparam int RATIO    = 4;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [IN_WIDTH-1:0]       data_i;
  logic                      valid_i;
  logic                      grant_o;
  logic                      flush_i;
  logic [IN_WIDTH*RATIO-1:0] data_o;
  logic [RATIO-1:0]          strb_o;
  logic                      valid_o;
  logic                      grant_i;

  int checks = 0;
  int errors = 0;

  fifo_word_packer #(
    .IN_WIDTH(IN_WIDTH),
    .RATIO   (RATIO)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .data_i (data_i),
    .valid_i(valid_i),
    .grant_o(grant_o),
    .flush_i(flush_i),
    .data_o (data_o),
    .strb_o (strb_o),
    .valid_o(valid_o),
    .grant_i(grant_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic g, input logic f);
    valid_i = v;
    data_i  = d;
    grant_i = g;
    flush_i = f;
    #1;
  endtask

  logic [127:0] exp_word;
  logic [127:0] held;
  int           groups;

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    check("rst_valid", valid_o, 0);
    check("rst_data",  data_o,  0);
    check("rst_strb",  strb_o,  0);
    check("rst_grant", grant_o, 1);
    rst = 1'b0;

    // Basic group with consumer ready
    drive(1'b1, 32'h11, 1'b1, 1'b0); check("t1_grant0", grant_o, 1); tick();
    drive(1'b1, 32'h22, 1'b1, 1'b0); check("t1_valid1", valid_o, 0); tick();
    drive(1'b1, 32'h33, 1'b1, 1'b0); check("t1_valid2", valid_o, 0); tick();
    drive(1'b1, 32'h44, 1'b1, 1'b0); check("t1_valid3", valid_o, 0); tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    check("t1_valid_hi", valid_o, 1);
    check("t1_data", data_o, 128'h00000044_00000033_00000022_00000011);
    check("t1_strb", strb_o, 4'hF);
    check("t1_grant_hold", grant_o, 1);
    tick();
    check("t1_valid_lo", valid_o, 0);
    check("t1_cleared", data_o, 0);

    // Consumer backpressure for 5 cycles
    drive(1'b1, 32'h55, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h66, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h77, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h88, 1'b0, 1'b0); tick();
    held = 128'h00000088_00000077_00000066_00000055;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h99, 1'b0, 1'b0);
      check("t2_stall_valid", valid_o, 1);
      check("t2_stall_grant", grant_o, 0);
      check("t2_stall_data",  data_o,  held);
      tick();
    end
    drive(1'b1, 32'h99, 1'b1, 1'b0);
    check("t2_grant_cycle", grant_o, 1);
    check("t2_data_final",  data_o,  held);
    tick();
    drive(1'b1, 32'hAA, 1'b1, 1'b0);
    check("t2_valid_lo", valid_o, 0);
    check("t2_slot0",    data_o,  128'h99);
    check("t2_strb0",    strb_o,  4'h1);
    tick();
    drive(1'b1, 32'hBB, 1'b1, 1'b0); tick();
    drive(1'b1, 32'hCC, 1'b1, 1'b0); tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    check("t2_valid2", valid_o, 1);
    check("t2_data2",  data_o,  128'h000000CC_000000BB_000000AA_00000099);
    tick();

    // 16 words streamed continuously
    groups = 0;
    for (int c = 0; c <= 16; c++) begin
      drive(c < 16, 32'h100 + c, 1'b1, 1'b0);
      check("t3_valid", valid_o, (c >= 4 && c % 4 == 0) ? 1 : 0);
      if (c >= 4 && c % 4 == 0) begin
        exp_word = '0;
        for (int k = 0; k < 4; k++)
          exp_word[k*32 +: 32] = 32'h100 + (c - 4) + k;
        check("t3_data", data_o, exp_word);
        check("t3_strb", strb_o, 4'hF);
        groups++;
      end
      tick();
    end
    check("t3_groups", groups, 4);
    check("t3_idle", valid_o, 0);

    // Reset mid-word
    drive(1'b1, 32'hE1, 1'b1, 1'b0); tick();
    drive(1'b1, 32'hE2, 1'b1, 1'b0); tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t4_rst_valid", valid_o, 0);
    check("t4_rst_data",  data_o,  0);
    check("t4_rst_strb",  strb_o,  0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'hF1 + i, 1'b1, 1'b0);
      check("t4_no_early", valid_o, 0);
      tick();
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    check("t4_valid", valid_o, 1);
    check("t4_data",  data_o,  128'h000000F4_000000F3_000000F2_000000F1);
    check("t4_strb",  strb_o,  4'hF);
    tick();

`ifdef PACKER_FLUSH_EN
    // Flush on an empty group does nothing
    drive(1'b0, 32'h0, 1'b1, 1'b1); tick();
    check("t5_empty_flush", valid_o, 0);
    drive(1'b1, 32'hA, 1'b0, 1'b0); tick();
    drive(1'b1, 32'hB, 1'b0, 1'b0); tick();
    drive(1'b1, 32'hC, 1'b0, 1'b1); tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    check("t5_valid", valid_o, 1);
    check("t5_strb",  strb_o,  4'h7);
    check("t5_data",  data_o,  128'h00000000_0000000C_0000000B_0000000A);
    tick();
    check("t5_hold_flush", valid_o, 1);
    check("t5_hold_data",  data_o,  128'h00000000_0000000C_0000000B_0000000A);
    drive(1'b0, 32'h0, 1'b1, 1'b0); tick();
    check("t5_release", valid_o, 0);
`else
    // Flush is inert without the feature
    drive(1'b1, 32'hD1, 1'b1, 1'b0); tick();
    drive(1'b0, 32'h0, 1'b1, 1'b1); tick();
    check("t5_no_flush", valid_o, 0);
    drive(1'b1, 32'hD2, 1'b1, 1'b1); tick();
    check("t5_no_flush2", valid_o, 0);
    drive(1'b1, 32'hD3, 1'b1, 1'b0); tick();
    drive(1'b1, 32'hD4, 1'b1, 1'b0); tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    check("t5_valid", valid_o, 1);
    check("t5_strb",  strb_o,  4'hF);
    check("t5_data",  data_o,  128'h000000D4_000000D3_000000D2_000000D1);
    tick();
    check("t5_release", valid_o, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
